multi_pipe_param: RTL and testbench

Parametrised pipelined array multiplier: next generation of the team's fixed 8-bit pipelined multiplier. Adds configurable operand width, a per-transaction signed/unsigned mode, valid/ready handshaking with full backpressure, and a synchronous flush. Sits between operand producers (DSP datapath, address generators) and consumers that may stall.

---
 rtl/multi_pipe_param_pkg.sv | 20 ++
 rtl/multi_pipe_param_if.sv | 24 ++
 rtl/multi_pipe_param_mult_add_stage.sv | 38 +++
 rtl/multi_pipe_param.sv | 117 +++++++++++
 tb/tb_multi_pipe_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_pipe_param_pkg.sv
// Shared types and helpers for the multi_pipe_param pipelined multiplier.
package multi_pipe_pkg;

  localparam int unsigned MIN_WIDTH = 4;

  // The data field's width depends on the tree level, so each level carries
  // its data as a parallel vector next to this record.
  typedef struct packed {
    logic valid;
    logic neg;
  } stage_rec_t;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/multi_pipe_param_if.sv
// Operand/product handshake bundle for multi_pipe_param.
interface multi_pipe_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 mul_flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mul_signed;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   mul_out;

  modport master (
    output mul_flush, in_valid, mul_signed, mul_a, mul_b, out_ready,
    input  in_ready, out_valid, mul_out
  );

  modport slave (
    input  mul_flush, in_valid, mul_signed, mul_a, mul_b, out_ready,
    output in_ready, out_valid, mul_out
  );
endinterface

// File: rtl/multi_pipe_param_mult_add_stage.sv
// One registered level of the pairwise adder tree: N inputs -> N/2 sums.
module mult_add_stage
  import multi_pipe_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    adv,
  input  stage_rec_t              in_rec,
  input  logic [N-1:0][DW-1:0]    in_data,
  output stage_rec_t              out_rec,
  output logic [N/2-1:0][DW-1:0]  out_data
);

  logic [N/2-1:0][DW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N/2; i++) begin
      sum[i] = in_data[2*i] + in_data[2*i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rec  <= '0;
      out_data <= '0;
    end else begin
      if (flush)    out_rec.valid <= 1'b0;
      else if (adv) out_rec       <= in_rec;
      if (adv) out_data <= sum;
    end
  end

endmodule

// File: rtl/multi_pipe_param.sv
// Parametrised pipelined array multiplier with valid/ready and flush.
// Define MULT_PIPE_ZERO_GATE_EN to force mul_out to 0 whenever out_valid is 0.
module multi_pipe_param
  import multi_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_pipe_param_if.slave   bus
);

  localparam int unsigned L  = clog2_f(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  if (WIDTH < MIN_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("multi_pipe_param: WIDTH must be a power of two >= 4");
  end

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !bus.mul_flush;

  // Magnitude fits in WIDTH bits: -2^(WIDTH-1) negates to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  stage_rec_t       s0_rec;
  logic [WIDTH-1:0] a_mag_q;
  logic [WIDTH-1:0] b_mag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_rec  <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
    end else begin
      if (bus.mul_flush) begin
        s0_rec.valid <= 1'b0;
      end else if (adv) begin
        s0_rec.valid <= bus.in_valid;
        s0_rec.neg   <= bus.mul_signed && (bus.mul_a[WIDTH-1] ^ bus.mul_b[WIDTH-1]);
      end
      if (adv) begin
        a_mag_q <= mag_f(bus.mul_a, bus.mul_signed);
        b_mag_q <= mag_f(bus.mul_b, bus.mul_signed);
      end
    end
  end

  logic [WIDTH-1:0][PW-1:0] pp;

  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp[i] = b_mag_q[i] ? (PW'(a_mag_q) << i) : '0;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_tree
    localparam int unsigned N = WIDTH >> k;
    stage_rec_t               rec_in;
    stage_rec_t               rec_q;
    logic [N-1:0][PW-1:0]     data_in;
    logic [N/2-1:0][PW-1:0]   data_q;

    if (k == 0) begin : g_first
      assign rec_in  = s0_rec;
      assign data_in = pp;
    end else begin : g_next
      assign rec_in  = g_tree[k-1].rec_q;
      assign data_in = g_tree[k-1].data_q;
    end

    mult_add_stage #(.N(N), .DW(PW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.mul_flush),
      .adv      (adv),
      .in_rec   (rec_in),
      .in_data  (data_in),
      .out_rec  (rec_q),
      .out_data (data_q)
    );
  end

  stage_rec_t    tree_rec;
  logic [PW-1:0] tree_sum;
  logic          out_valid_q;
  logic [PW-1:0] prod_q;

  assign tree_rec = g_tree[L-1].rec_q;
  assign tree_sum = g_tree[L-1].data_q;

  // The product register only loads real results, so it holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
    end else begin
      if (bus.mul_flush) out_valid_q <= 1'b0;
      else if (adv)      out_valid_q <= tree_rec.valid;
      if (adv && tree_rec.valid && !bus.mul_flush) begin
        prod_q <= tree_rec.neg ? -tree_sum : tree_sum;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
`ifdef MULT_PIPE_ZERO_GATE_EN
  assign bus.mul_out = out_valid_q ? prod_q : '0;
`else
  assign bus.mul_out = prod_q;
`endif

endmodule

// File: tb/tb_multi_pipe_param.sv
// Directed bench for multi_pipe_param at WIDTH=8 and WIDTH=16.
module tb_multi_pipe_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_pipe_param_if #(.WIDTH(8))  b8();
  multi_pipe_param_if #(.WIDTH(16)) b16();

  multi_pipe_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  multi_pipe_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  task automatic single8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [15:0] exp);
    @(negedge clk);
    b8.in_valid = 1'b1; b8.mul_a = a; b8.mul_b = b; b8.mul_signed = s;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      b8.in_valid = 1'b0;
      if (k < 5) check({name, "_early"}, 64'(b8.out_valid), 64'd0);
      else begin
        check({name, "_valid"}, 64'(b8.out_valid), 64'd1);
        check({name, "_data"}, 64'(b8.mul_out), 64'(exp));
      end
    end
  endtask

  task automatic single16(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp);
    @(negedge clk);
    b16.in_valid = 1'b1; b16.mul_a = a; b16.mul_b = b; b16.mul_signed = s;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b16.in_valid = 1'b0;
      if (k < 6) check({name, "_early"}, 64'(b16.out_valid), 64'd0);
      else begin
        check({name, "_valid"}, 64'(b16.out_valid), 64'd1);
        check({name, "_data"}, 64'(b16.mul_out), 64'(exp));
      end
    end
  endtask

  initial begin
    logic [15:0] sb[$];
    logic [15:0] held;
    logic [15:0] exp_v;
    logic        stalled;
    logic        accepted;
    logic [7:0]  pa, pb;
    logic        ps;
    int          sent, got, cnt;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[4]  = '{8'h00, 8'hFB, 1'b1, 16'h0000};
    vecs[5]  = '{8'h07, 8'h09, 1'b0, 16'h003F};
    vecs[6]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[8]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[9]  = '{8'hFF, 8'h80, 1'b0, 16'h7F80};
    vecs[10] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

    b8.mul_flush = 1'b0;  b8.in_valid = 1'b0;  b8.mul_signed = 1'b0;
    b8.mul_a = '0;  b8.mul_b = '0;  b8.out_ready = 1'b1;
    b16.mul_flush = 1'b0; b16.in_valid = 1'b0; b16.mul_signed = 1'b0;
    b16.mul_a = '0; b16.mul_b = '0; b16.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("rst_mul_out", 64'(b8.mul_out), 64'd0);
    check("rst_out_valid16", 64'(b16.out_valid), 64'd0);
    check("rst_mul_out16", 64'(b16.mul_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(b8.in_ready), 64'd1);

    // Back-to-back table stream, out_ready held high
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 5 && t < 16) begin
        check("stream_valid", 64'(b8.out_valid), 64'd1);
        check("stream_data", 64'(b8.mul_out), 64'(vecs[t-5].exp));
      end else begin
        check("stream_latency_valid", 64'(b8.out_valid), 64'd0);
      end
      if (t < 11) begin
        b8.in_valid = 1'b1; b8.mul_a = vecs[t].a; b8.mul_b = vecs[t].b;
        b8.mul_signed = vecs[t].sgn;
        check("stream_in_ready", 64'(b8.in_ready), 64'd1);
      end else begin
        b8.in_valid = 1'b0;
      end
    end

    // Random backpressure with scoreboard
    sent = 0; got = 0; stalled = 1'b0; accepted = 1'b1; held = '0;
    pa = '0; pb = '0; ps = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid_hold", 64'(b8.out_valid), 64'd1);
        check("stall_data_hold", 64'(b8.mul_out), 64'(held));
      end
      if (accepted) begin
        pa = 8'($urandom); pb = 8'($urandom); ps = 1'($urandom);
      end
      b8.out_ready  = 1'($urandom_range(0, 1));
      b8.in_valid   = (sent < 10);
      b8.mul_a = pa; b8.mul_b = pb; b8.mul_signed = ps;
      #1;
      accepted = b8.in_valid && b8.in_ready;
      if (accepted) begin
        sb.push_back(model8(pa, pb, ps));
        sent++;
      end
      if (b8.out_valid && !b8.out_ready) check("stall_in_ready", 64'(b8.in_ready), 64'd0);
      if (b8.out_valid && b8.out_ready) begin
        exp_v = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check("bp_data", 64'(b8.mul_out), 64'(exp_v));
        got++;
      end
      stalled = b8.out_valid && !b8.out_ready;
      held    = b8.mul_out;
    end
    check("bp_count", 64'(got), 64'd10);
    @(negedge clk);
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;

    // Flush with three in flight plus a dropped input during flush
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      b8.in_valid = 1'b1; b8.mul_a = 8'(t + 2); b8.mul_b = 8'h03; b8.mul_signed = 1'b0;
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(negedge clk);
    b8.mul_flush = 1'b1; b8.in_valid = 1'b1; b8.mul_a = 8'h05; b8.mul_b = 8'h05;
    #1;
    check("flush_in_ready", 64'(b8.in_ready), 64'd0);
    @(negedge clk);
    b8.mul_flush = 1'b0; b8.in_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (b8.out_valid) cnt++;
      @(negedge clk);
    end
    check("flush_no_output", 64'(cnt), 64'd0);
    single8("flush_recover", 8'h07, 8'h09, 1'b0, 16'h003F);

    // Reset with four in flight
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      b8.in_valid = 1'b1; b8.mul_a = 8'(t + 10); b8.mul_b = 8'h11; b8.mul_signed = 1'b0;
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(b8.out_valid), 64'd0);
    check("midrst_mul_out", 64'(b8.mul_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (b8.out_valid) cnt++;
    end
    check("midrst_no_stale", 64'(cnt), 64'd0);

    // WIDTH=16 corners
    single16("w16_unsigned", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    single16("w16_signed", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    single16("w16_minneg", 16'h8000, 16'h8000, 1'b1, 32'h40000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
